// File: rtl/cpu_pkg.sv
// Shared definitions for the 5-stage RISC-V core: data width, bubble encoding,
// default reset vector and the fetch-stage state encoding.
package cpu_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR_ENC    = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    FETCH_IDLE,
    FETCH_RUN
  } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: holds pc/instr/valid, with hold (stall) and bubble
// (squash/idle) controls. load_pc selects whether the pc field follows fetch.
module if_id_reg
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_ENC
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            hold,
  input  logic            bubble,
  input  logic            load_pc,
  input  logic [XLEN-1:0] fetch_pc,
  input  logic [XLEN-1:0] fetch_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_instr,
  output logic            id_valid
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      id_pc    <= '0;
      id_instr <= NOP_INSTR;
      id_valid <= 1'b0;
    end else if (!hold) begin
      if (load_pc) begin
        id_pc <= fetch_pc;
      end
      id_instr <= bubble ? NOP_INSTR : fetch_instr;
      id_valid <= !bubble;
    end
  end

endmodule

// File: rtl/if_id_fetch_stage.sv
// Instruction fetch stage: PC register, IDLE/RUN sequencing, redirect on flush,
// feeding the IF/ID register. Optional counters under IF_ID_PERF_CNT_EN.
module if_id_fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_ENC
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        PCWrite_i,
  input  logic        Stall_i,
  input  logic        Flush_i,
  input  logic [31:0] Branch_target_i,
  output logic [31:0] IMEM_addr_o,
  input  logic [31:0] IMEM_instr_i,
  output logic [31:0] ID_pc_o,
  output logic [31:0] ID_instr_o,
  output logic        ID_valid_o
`ifdef IF_ID_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
`endif
);

  fetch_state_e state;
  logic [31:0]  pc;
  logic         run;
  logic         hold;
  logic         flush_eff;
  logic         bubble;

  // Stall outranks flush: the branch being resolved in ID is itself held.
  always_comb begin
    run       = (state == FETCH_RUN);
    hold      = run && Stall_i;
    flush_eff = run && Flush_i && !Stall_i;
    bubble    = !run || flush_eff;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      pc    <= RESET_PC;
      state <= FETCH_IDLE;
    end else begin
      case (state)
        FETCH_IDLE: begin
          if (start_i) begin
            state <= FETCH_RUN;
          end
        end
        FETCH_RUN: begin
          if (PCWrite_i) begin
            pc <= flush_eff ? {Branch_target_i[31:2], 2'b00} : pc + 32'd4;
          end
        end
        default: state <= FETCH_IDLE;
      endcase
    end
  end

  assign IMEM_addr_o = pc;

  if_id_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id_reg (
    .clk        (clk_i),
    .rst_n      (rst_i),
    .hold       (hold),
    .bubble     (bubble),
    .load_pc    (run),
    .fetch_pc   (pc),
    .fetch_instr(IMEM_instr_i),
    .id_pc      (ID_pc_o),
    .id_instr   (ID_instr_o),
    .id_valid   (ID_valid_o)
  );

`ifdef IF_ID_PERF_CNT_EN
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (hold && (stall_cnt_o != '1)) begin
        stall_cnt_o <= stall_cnt_o + 32'd1;
      end
      if (flush_eff && (flush_cnt_o != '1)) begin
        flush_cnt_o <= flush_cnt_o + 32'd1;
      end
    end
  end
`endif

  // A squash without PC update loses the redirect; the hazard unit must not do this.
  a_flush_needs_pcwrite : assert property (
    @(posedge clk_i) disable iff (!rst_i) !(flush_eff && !PCWrite_i)
  );

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Directed self-checking bench for if_id_fetch_stage; counter checks are
// active when IF_ID_PERF_CNT_EN is defined.
module tb_if_id_fetch_stage;

  logic        clk = 1'b0;
  logic        rst, start, pcwrite, stall, flush;
  logic [31:0] target, addr, imem, id_pc, id_instr;
  logic        id_valid;
`ifdef IF_ID_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Address-tagged instruction memory: word at A reads as C0DE_xxxx (low half of A).
  assign imem = 32'hC0DE_0000 | (addr & 32'h0000_FFFF);

  if_id_fetch_stage dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .start_i        (start),
    .PCWrite_i      (pcwrite),
    .Stall_i        (stall),
    .Flush_i        (flush),
    .Branch_target_i(target),
    .IMEM_addr_o    (addr),
    .IMEM_instr_i   (imem),
    .ID_pc_o        (id_pc),
    .ID_instr_o     (id_instr),
    .ID_valid_o     (id_valid)
`ifdef IF_ID_PERF_CNT_EN
    ,
    .stall_cnt_o    (stall_cnt),
    .flush_cnt_o    (flush_cnt)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reset for one edge, then sample start once; leaves the stage in RUN with PC=0.
  task automatic restart;
    rst = 1'b0; start = 1'b0; stall = 1'b0; flush = 1'b0; pcwrite = 1'b1; target = '0;
    tick();
    rst = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0; start = 1'b0; stall = 1'b0; flush = 1'b0; pcwrite = 1'b1; target = '0;
    tick();
    tick();
    checks++; if (addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp %h", addr, 32'h0); end
    checks++; if (id_instr !== 32'h13) begin errors++; $display("FAIL reset_instr got %h exp %h", id_instr, 32'h13); end
    checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp %h", id_pc, 32'h0); end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", id_valid); end
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (addr !== 32'h0) begin errors++; $display("FAIL idle_addr[%0d] got %h exp %h", i, addr, 32'h0); end
      checks++; if (id_instr !== 32'h13) begin errors++; $display("FAIL idle_instr[%0d] got %h exp %h", i, id_instr, 32'h13); end
      checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL idle_valid[%0d] got %b exp 0", i, id_valid); end
    end
  endtask

  task automatic test_seq_fetch;
    logic [31:0] exp_pc [4];
    logic [31:0] exp_in [4];
    exp_pc = '{32'h0, 32'h4, 32'h8, 32'hC};
    exp_in = '{32'hC0DE_0000, 32'hC0DE_0004, 32'hC0DE_0008, 32'hC0DE_000C};
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (addr !== 32'h0) begin errors++; $display("FAIL start_edge_addr got %h exp %h", addr, 32'h0); end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL start_edge_valid got %b exp 0", id_valid); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (id_pc !== exp_pc[i]) begin errors++; $display("FAIL seq_pc[%0d] got %h exp %h", i, id_pc, exp_pc[i]); end
      checks++; if (id_instr !== exp_in[i]) begin errors++; $display("FAIL seq_instr[%0d] got %h exp %h", i, id_instr, exp_in[i]); end
      checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL seq_valid[%0d] got %b exp 1", i, id_valid); end
    end
    checks++; if (addr !== 32'h10) begin errors++; $display("FAIL seq_addr got %h exp %h", addr, 32'h10); end
  endtask

  task automatic test_load_use_stall;
    restart();
    tick();
    tick();
    checks++; if (addr !== 32'h8) begin errors++; $display("FAIL pre_stall_addr got %h exp %h", addr, 32'h8); end
    stall = 1'b1; pcwrite = 1'b0;
    tick();
    checks++; if (addr !== 32'h8) begin errors++; $display("FAIL stall_addr got %h exp %h", addr, 32'h8); end
    checks++; if (id_pc !== 32'h4) begin errors++; $display("FAIL stall_hold_pc got %h exp %h", id_pc, 32'h4); end
    checks++; if (id_instr !== 32'hC0DE_0004) begin errors++; $display("FAIL stall_hold_instr got %h exp %h", id_instr, 32'hC0DE_0004); end
    checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL stall_hold_valid got %b exp 1", id_valid); end
    stall = 1'b0; pcwrite = 1'b1;
    tick();
    checks++; if (id_pc !== 32'h8) begin errors++; $display("FAIL post_stall_pc0 got %h exp %h", id_pc, 32'h8); end
    tick();
    checks++; if (id_pc !== 32'hC) begin errors++; $display("FAIL post_stall_pc1 got %h exp %h", id_pc, 32'hC); end
  endtask

  task automatic test_pcwrite_hold;
    restart();
    pcwrite = 1'b0;
    tick();
    checks++; if (addr !== 32'h0) begin errors++; $display("FAIL pcw_hold_addr got %h exp %h", addr, 32'h0); end
    checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL pcw_hold_valid got %b exp 1", id_valid); end
    tick();
    checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL pcw_hold_pc got %h exp %h", id_pc, 32'h0); end
    pcwrite = 1'b1;
  endtask

  task automatic test_branch_flush;
    restart();
    tick(); tick(); tick();
    flush = 1'b1; target = 32'h0000_0041;
    tick();
    flush = 1'b0;
    checks++; if (addr !== 32'h40) begin errors++; $display("FAIL flush_addr got %h exp %h", addr, 32'h40); end
    checks++; if (id_instr !== 32'h13) begin errors++; $display("FAIL flush_instr got %h exp %h", id_instr, 32'h13); end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b exp 0", id_valid); end
    checks++; if (id_pc !== 32'hC) begin errors++; $display("FAIL flush_pc got %h exp %h", id_pc, 32'hC); end
    tick();
    checks++; if (id_pc !== 32'h40) begin errors++; $display("FAIL target_pc got %h exp %h", id_pc, 32'h40); end
    checks++; if (id_instr !== 32'hC0DE_0040) begin errors++; $display("FAIL target_instr got %h exp %h", id_instr, 32'hC0DE_0040); end
    checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL target_valid got %b exp 1", id_valid); end
    tick();
    checks++; if (id_pc !== 32'h44) begin errors++; $display("FAIL target_next_pc got %h exp %h", id_pc, 32'h44); end
  endtask

  task automatic test_stall_flush;
    restart();
    tick(); tick(); tick();
    stall = 1'b1; flush = 1'b1; pcwrite = 1'b0; target = 32'h80;
    tick();
    checks++; if (addr !== 32'hC) begin errors++; $display("FAIL sf_addr got %h exp %h", addr, 32'hC); end
    checks++; if (id_pc !== 32'h8) begin errors++; $display("FAIL sf_hold_pc got %h exp %h", id_pc, 32'h8); end
    checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL sf_hold_valid got %b exp 1", id_valid); end
    stall = 1'b0; pcwrite = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (addr !== 32'h80) begin errors++; $display("FAIL sf_redirect_addr got %h exp %h", addr, 32'h80); end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL sf_bubble_valid got %b exp 0", id_valid); end
    checks++; if (id_pc !== 32'hC) begin errors++; $display("FAIL sf_bubble_pc got %h exp %h", id_pc, 32'hC); end
`ifdef IF_ID_PERF_CNT_EN
    checks++; if (stall_cnt !== 32'd1) begin errors++; $display("FAIL stall_cnt got %0d exp 1", stall_cnt); end
    checks++; if (flush_cnt !== 32'd1) begin errors++; $display("FAIL flush_cnt got %0d exp 1", flush_cnt); end
`endif
    tick();
    checks++; if (id_pc !== 32'h80) begin errors++; $display("FAIL sf_target_pc got %h exp %h", id_pc, 32'h80); end
  endtask

  task automatic test_wrap_and_reset;
    restart();
    flush = 1'b1; target = 32'hFFFF_FFFF;
    tick();
    flush = 1'b0;
    checks++; if (addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL align_addr got %h exp %h", addr, 32'hFFFF_FFFC); end
    tick();
    checks++; if (addr !== 32'h0) begin errors++; $display("FAIL wrap_addr got %h exp %h", addr, 32'h0); end
    checks++; if (id_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_id_pc got %h exp %h", id_pc, 32'hFFFF_FFFC); end
    checks++; if (id_instr !== 32'hC0DE_FFFC) begin errors++; $display("FAIL wrap_id_instr got %h exp %h", id_instr, 32'hC0DE_FFFC); end
    tick(); tick();
    checks++; if (id_pc !== 32'h4) begin errors++; $display("FAIL pre_rst_pc got %h exp %h", id_pc, 32'h4); end
    rst = 1'b0;
    tick();
    checks++; if (addr !== 32'h0) begin errors++; $display("FAIL midrst_addr got %h exp %h", addr, 32'h0); end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b exp 0", id_valid); end
    checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL midrst_pc got %h exp %h", id_pc, 32'h0); end
    checks++; if (id_instr !== 32'h13) begin errors++; $display("FAIL midrst_instr got %h exp %h", id_instr, 32'h13); end
`ifdef IF_ID_PERF_CNT_EN
    checks++; if (flush_cnt !== 32'd0) begin errors++; $display("FAIL midrst_flush_cnt got %0d exp 0", flush_cnt); end
`endif
    rst = 1'b1;
    tick(); tick();
    checks++; if (addr !== 32'h0) begin errors++; $display("FAIL post_rst_idle_addr got %h exp %h", addr, 32'h0); end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL post_rst_idle_valid got %b exp 0", id_valid); end
  endtask

  initial begin
    test_reset();
    test_seq_fetch();
    test_load_use_stall();
    test_pcwrite_hold();
    test_branch_flush();
    test_stall_flush();
    test_wrap_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
